// File: rtl/cpu_pkg.sv
// Shared constants for the sequential CPU control path.
//   opcode encodings (3-bit IR field), ALU function selects and the
//   step (T-state) encoding that is also exported on the step port.
package cpu_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

endpackage

// File: rtl/sel_decoder.sv
// Binary-to-one-hot register select decoder.
//   sel    : SEL_W-bit register index
//   en     : enable; when low the output is all zeros
//   onehot : NUM_REGS-bit one-hot select (bit sel set when en=1)
module sel_decoder #(
  parameter int NUM_REGS = 8,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  always_comb begin
    // NOTE: the default assignment before any conditional write keeps this
    // block purely combinational; without it an unwritten path infers a latch.
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle control unit for a small register-file CPU.
//   clk          : clock, all state on the rising edge
//   rst          : synchronous active-low reset; also blanks all outputs
//   run          : start request, sampled in T0
//   din          : instruction word {opcode, dst, src}, captured in T0
//   g_zero       : datapath G register equals zero (mvnz condition)
//   hold         : stall request, honoured in T1..T3
//   reg_out      : one-hot register bus-drive selects
//   reg_in       : one-hot register load strobes
//   din_out, g_out, a_in, g_in, ir_in : bus-source and load strobes
//   alu_op       : ALU function, non-zero only in T2
//   done, illegal: single-cycle status pulses
//   step         : current T-state (0..3)
module seq_control_unit
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 8,
  localparam int SEL_W   = $clog2(NUM_REGS),
  localparam int INSTR_W = 3 + 2 * SEL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [INSTR_W-1:0]  din,
  input  logic                g_zero,
  input  logic                hold,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                din_out,
  output logic                g_out,
  output logic                a_in,
  output logic                g_in,
  output logic                ir_in,
  output logic [1:0]          alu_op,
  output logic                done,
  output logic                illegal,
  output logic [1:0]          step
);

  step_e              state, state_nxt;
  logic [INSTR_W-1:0] ir;
  logic               ir_load;

  logic [2:0]         op;
  logic [SEL_W-1:0]   dst, src;

  logic [SEL_W-1:0]   out_sel, in_sel;
  logic               out_en, in_en;

  // Decoded strobes before reset blanking.
  logic din_out_d, g_out_d, a_in_d, g_in_d, ir_in_d, done_d, illegal_d;
  logic [1:0] alu_op_d;

  assign op  = ir[INSTR_W-1 -: 3];
  assign dst = ir[2*SEL_W-1 -: SEL_W];
  assign src = ir[SEL_W-1:0];

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      state <= T0;
      // NOTE: IR is cleared on reset so a stale instruction can never be
      // decoded after reset is released.
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (ir_load) ir <= din;
    end
  end

  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    out_sel   = '0;
    out_en    = 1'b0;
    in_sel    = '0;
    in_en     = 1'b0;
    din_out_d = 1'b0;
    g_out_d   = 1'b0;
    a_in_d    = 1'b0;
    g_in_d    = 1'b0;
    ir_in_d   = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    alu_op_d  = ALU_ADD;

    unique case (state)
      T0: begin
        // hold has no effect here: fetch always proceeds.
        din_out_d = 1'b1;
        ir_in_d   = 1'b1;
        if (run) begin
          ir_load   = 1'b1;
          state_nxt = T1;
        end
      end

      T1: if (!hold) begin
        unique case (op)
          OP_MV, OP_MVNZ: begin
            // mvnz with G == 0 completes without touching any register.
            if (op == OP_MV || !g_zero) begin
              out_sel = src;
              out_en  = 1'b1;
              in_sel  = dst;
              in_en   = 1'b1;
            end
            done_d    = 1'b1;
            state_nxt = T0;
          end
          OP_MVI: begin
            din_out_d = 1'b1;
            in_sel    = dst;
            in_en     = 1'b1;
            done_d    = 1'b1;
            state_nxt = T0;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            out_sel   = dst;
            out_en    = 1'b1;
            a_in_d    = 1'b1;
            state_nxt = T2;
          end
          default: begin
            illegal_d = 1'b1;
            done_d    = 1'b1;
            state_nxt = T0;
          end
        endcase
      end

      T2: if (!hold) begin
        out_sel   = src;
        out_en    = 1'b1;
        g_in_d    = 1'b1;
        alu_op_d  = (op == OP_SUB) ? ALU_SUB :
                    (op == OP_AND) ? ALU_AND : ALU_ADD;
        state_nxt = T3;
      end

      T3: if (!hold) begin
        g_out_d   = 1'b1;
        in_sel    = dst;
        in_en     = 1'b1;
        done_d    = 1'b1;
        state_nxt = T0;
      end

      default: state_nxt = T0;
    endcase
  end

  // Both decoders are gated by rst so the one-hot buses are blanked in reset.
  sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_out_dec (
    .sel    (out_sel),
    .en     (out_en & rst),
    .onehot (reg_out)
  );

  sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_in_dec (
    .sel    (in_sel),
    .en     (in_en & rst),
    .onehot (reg_in)
  );

  assign din_out = din_out_d & rst;
  assign g_out   = g_out_d   & rst;
  assign a_in    = a_in_d    & rst;
  assign g_in    = g_in_d    & rst;
  assign ir_in   = ir_in_d   & rst;
  assign done    = done_d    & rst;
  assign illegal = illegal_d & rst;
  assign alu_op  = rst ? alu_op_d : 2'b00;
  assign step    = rst ? state    : 2'b00;

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed self-checking bench for seq_control_unit with NUM_REGS = 8.
module tb_seq_control_unit;

  localparam int NUM_REGS = 8;
  localparam int INSTR_W  = 9;

  logic                clk;
  logic                rst;
  logic                run;
  logic [INSTR_W-1:0]  din;
  logic                g_zero;
  logic                hold;
  logic [NUM_REGS-1:0] reg_out;
  logic [NUM_REGS-1:0] reg_in;
  logic                din_out, g_out, a_in, g_in, ir_in;
  logic [1:0]          alu_op;
  logic                done, illegal;
  logic [1:0]          step;

  int pass_cnt = 0;
  int total_cnt = 0;

  seq_control_unit #(.NUM_REGS(NUM_REGS)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .din     (din),
    .g_zero  (g_zero),
    .hold    (hold),
    .reg_out (reg_out),
    .reg_in  (reg_in),
    .din_out (din_out),
    .g_out   (g_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .ir_in   (ir_in),
    .alu_op  (alu_op),
    .done    (done),
    .illegal (illegal),
    .step    (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one rising edge, then move 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Every output at once: {reg_out, reg_in, din_out, g_out, a_in, g_in,
  // ir_in, alu_op, done, illegal, step}.
  function automatic logic [31:0] all_out();
    return {8'h0, reg_out, reg_in, din_out, g_out, a_in, g_in, ir_in,
            alu_op, done, illegal, step};
  endfunction

  initial begin
    int lat;
    rst = 1'b0; run = 1'b0; din = '0; g_zero = 1'b0; hold = 1'b0;

    // Reset: outputs forced low combinationally, even before any edge.
    #1;
    check("reset_outputs_pre_edge", all_out(), 32'h0);
    cyc(); cyc();
    check("reset_outputs", all_out(), 32'h0);
    rst = 1'b1; #1;
    check("t0_step", step, 2'd0);
    check("t0_fetch_strobes", {din_out, ir_in, reg_out, reg_in, done}, {1'b1, 1'b1, 8'h00, 8'h00, 1'b0});

    // mvi r3
    din = 9'b001_011_000; run = 1'b1;
    cyc(); run = 1'b0; #1;
    check("mvi_t1_step", step, 2'd1);
    check("mvi_t1", {din_out, reg_in, reg_out, done}, {1'b1, 8'h08, 8'h00, 1'b1});
    cyc();
    check("mvi_back_t0", {step, done}, {2'd0, 1'b0});

    // add r1,r2 (no hold): done 3 cycles after capture
    din = 9'b010_001_010; run = 1'b1;
    cyc(); run = 1'b0; #1;
    check("add_t1", {step, reg_out, a_in, done, reg_in}, {2'd1, 8'h02, 1'b1, 1'b0, 8'h00});
    cyc();
    check("add_t2", {step, reg_out, alu_op, g_in, a_in}, {2'd2, 8'h04, 2'b00, 1'b1, 1'b0});
    cyc();
    check("add_t3", {step, g_out, reg_in, done, reg_out, alu_op}, {2'd3, 1'b1, 8'h02, 1'b1, 8'h00, 2'b00});
    cyc();
    check("add_back_t0", {step, done}, {2'd0, 1'b0});

    // mvnz r4,r1 twice back-to-back with run held high
    din = 9'b101_100_001; run = 1'b1; g_zero = 1'b1;
    cyc();
    check("mvnz_gz1_t1", {step, done, reg_in}, {2'd1, 1'b1, 8'h00});
    cyc();
    check("mvnz_btb_t0", {step, done}, {2'd0, 1'b0});
    g_zero = 1'b0;
    cyc(); run = 1'b0; #1;
    check("mvnz_gz0_t1", {step, done, reg_out, reg_in}, {2'd1, 1'b1, 8'h02, 8'h10});
    cyc();

    // illegal opcode 111
    din = 9'b111_000_000; run = 1'b1;
    cyc(); run = 1'b0; #1;
    check("illegal_t1", {step, illegal, done, reg_in, a_in, g_in}, {2'd1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0});
    cyc();
    check("illegal_back_t0", {step, illegal, done}, {2'd0, 1'b0, 1'b0});

    // mv r6,r3 captured with hold=1 in T0 (hold ignored there)
    din = 9'b000_110_011; run = 1'b1; hold = 1'b1; #1;
    check("hold_ignored_t0", {din_out, ir_in}, {1'b1, 1'b1});
    cyc(); run = 1'b0; hold = 1'b0; #1;
    check("mv_t1", {step, reg_out, reg_in, done}, {2'd1, 8'h08, 8'h40, 1'b1});
    cyc();

    // sub r2,r5 with hold for 3 cycles in T2: done 6 cycles after capture
    din = 9'b011_010_101; run = 1'b1;
    cyc(); run = 1'b0; lat = 1; #1;
    check("sub_t1", {step, reg_out, a_in}, {2'd1, 8'h04, 1'b1});
    cyc(); lat++; hold = 1'b1; #1;
    check("sub_hold1", all_out(), {8'h0, 8'h00, 8'h00, 7'b0, 2'b00, 2'b00, 2'd2});
    cyc(); lat++;
    check("sub_hold2", all_out(), {8'h0, 8'h00, 8'h00, 7'b0, 2'b00, 2'b00, 2'd2});
    cyc(); lat++;
    check("sub_hold3", all_out(), {8'h0, 8'h00, 8'h00, 7'b0, 2'b00, 2'b00, 2'd2});
    cyc(); lat++; hold = 1'b0; #1;
    check("sub_t2_resume", {step, reg_out, g_in, alu_op}, {2'd2, 8'h20, 1'b1, 2'b01});
    cyc(); lat++;
    check("sub_t3", {step, g_out, reg_in, done}, {2'd3, 1'b1, 8'h04, 1'b1});
    check("sub_latency", lat, 6);
    cyc();

    // Reset asserted during T2 of add r1,r2
    din = 9'b010_001_010; run = 1'b1;
    cyc(); run = 1'b0; #1;
    cyc();
    check("rst_mid_pre", step, 2'd2);
    rst = 1'b0; #1;
    check("rst_mid_outputs", all_out(), 32'h0);
    cyc(); rst = 1'b1; #1;
    check("rst_release_t0", {step, done, din_out}, {2'd0, 1'b0, 1'b1});
    cyc();
    check("rst_no_done", {step, done, g_out, reg_in}, {2'd0, 1'b0, 1'b0, 8'h00});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_control_unit.md
SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, meaning general-purpose register count; legal values are the powers of two from 2 to 16.
REQ-002 SHALL have derived constant SEL_W = clog2(NUM_REGS), meaning the register-select field width.
REQ-003 SHALL have derived constant INSTR_W = 3 + 2*SEL_W, meaning the instruction width: [INSTR_W-1 -: 3] opcode, then dest field (SEL_W bits), then source field (SEL_W bits, LSBs).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port run, input, 1 bit: start request, sampled in T0 only.
REQ-007 SHALL have port din, input, INSTR_W bits: instruction word, captured in T0.
REQ-008 SHALL have port g_zero, input, 1 bit: high when the datapath G register equals zero.
REQ-009 SHALL have port hold, input, 1 bit: stall request.
REQ-010 SHALL have port reg_out, output, NUM_REGS bits: one-hot bus-drive select for the registers.
REQ-011 SHALL have port reg_in, output, NUM_REGS bits: one-hot load strobes for the registers.
REQ-012 SHALL have ports din_out, g_out, a_in, g_in and ir_in, each an output of 1 bit: bus-source and load strobes.
REQ-013 SHALL have port alu_op, output, 2 bits: ALU function select.
REQ-014 SHALL have ports done and illegal, each an output of 1 bit: single-cycle status pulses.
REQ-015 SHALL have port step, output, 2 bits: current step encoding, T0=0 to T3=3.

Function
REQ-016 SHALL implement an internal step FSM with states T0, T1, T2 and T3, plus an internal IR register of INSTR_W bits.
REQ-017 In T0, the block SHALL assert din_out=1 and ir_in=1; if run=1, it SHALL load IR from din and move to T1; otherwise it SHALL stay in T0 with IR unchanged.
REQ-018 SHALL use opcodes 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 mvnz; opcodes 110 and 111 are illegal.
REQ-019 For mv in T1: reg_out[src]=1, reg_in[dst]=1, done=1, next state T0.
REQ-020 For mvi in T1: din_out=1, reg_in[dst]=1, done=1, next state T0.
REQ-021 For mvnz in T1: if g_zero=0, behave as mv; if g_zero=1, assert no reg_in bit; in both cases done=1 and next state T0.
REQ-022 For add, sub and and in T1: reg_out[dst]=1 and a_in=1, next state T2.
REQ-023 For add, sub and and in T2: reg_out[src]=1, g_in=1 and alu_op set, next state T3.
REQ-024 For add, sub and and in T3: g_out=1, reg_in[dst]=1, done=1, next state T0.
REQ-025 SHALL encode alu_op as ADD=00, SUB=01, AND=10; alu_op SHALL be 00 in every cycle except T2.
REQ-026 For an illegal opcode in T1: illegal=1 and done=1, no reg_in, a_in or g_in asserted, next state T0.
REQ-027 At most one reg_out bit, or g_out, or din_out SHALL be high in any cycle (single bus driver).
REQ-028 All strobes SHALL be combinational decodes of the state, IR, g_zero and hold; no strobe is registered.
REQ-029 hold=1 in T1, T2 or T3 SHALL force every strobe, done and illegal to 0 and keep the state unchanged; decoding resumes exactly where it stopped on the first cycle with hold=0.
REQ-030 hold SHALL be ignored in T0.
REQ-031 Latency from the run-capture edge to done SHALL be 1 cycle for mv, mvi, mvnz and illegal opcodes, and 3 cycles for add, sub and and, with zero hold cycles.
REQ-032 Back-to-back instructions: with run held at 1, a new instruction SHALL be captured in the T0 that immediately follows done.
REQ-033 A register select greater than or equal to NUM_REGS cannot occur, because the field width is exactly SEL_W.

Reset
REQ-034 While rst=0 at a clock edge, the next state SHALL be T0 and IR SHALL be 0.
REQ-035 While rst=0, every output (reg_out, reg_in, strobes, alu_op, done, illegal and step) SHALL be forced to 0 combinationally.
REQ-036 Reset asserted mid-instruction SHALL abandon that instruction with no further strobes; no done pulse is issued for it.

Structure
REQ-037 SHALL place the opcode constants, the alu_op constants and the step encodings in the shared package cpu_pkg.
REQ-038 SHALL use one sub-module, sel_decoder (SEL_W-bit select plus enable in, NUM_REGS-bit one-hot out), instantiated once for reg_out and once for reg_in.

Verification
REQ-039 Verification SHALL cover, with NUM_REGS=8 throughout: run=1, din=001_011_000 (mvi r3) -> next cycle T1: din_out=1, reg_in=00001000, done=1; the cycle after that is T0.
REQ-040 Verification SHALL cover: din=010_001_010 (add r1,r2) -> T1: reg_out=00000010 and a_in=1; T2: reg_out=00000100, alu_op=00, g_in=1; T3: g_out=1, reg_in=00000010, done=1.
REQ-041 Verification SHALL cover: din=101_100_001 (mvnz r4,r1) with g_zero=1 -> T1: done=1, reg_in=0; repeated with g_zero=0 -> reg_out=00000010 and reg_in=00010000.
REQ-042 Verification SHALL cover: din=111_000_000 -> T1: illegal=1, done=1, all load strobes 0.
REQ-043 Verification SHALL cover: sub r2,r5 with hold=1 for 3 cycles on entering T2 -> step stays 2 and strobes stay 0; once hold=0, T2 decodes with alu_op=01 and done arrives 3 cycles later than with no hold.
REQ-044 Verification SHALL cover: rst=0 during T2 of an add -> all outputs 0 that cycle; after release, step=0 with no done pulse.
